// File: rtl/paicore_run_sequencer_if.sv
// Run-sequencer bus: regfile config/status plus datapath gating and handshake strobes.
//   i_start/i_abort/i_send_len/i_frame_num_max : run control from the regfile
//   i_tx_beat/i_rx_tlast                       : accepted CPU->FIFO beat / SNN->CPU frame end
//   o_dp_rst_n/o_paicore_ctrl/o_tx_en          : datapath reset, core phase, send gate
//   o_tx_done/o_rx_done/o_busy/o_err_timeout   : status levels back to the regfile
//   o_state/o_tx_cnt/o_rx_cnt                  : debug readback
interface paicore_run_sequencer_if;
  logic        i_start;
  logic        i_abort;
  logic [31:0] i_send_len;
  logic [31:0] i_frame_num_max;
  logic        i_tx_beat;
  logic        i_rx_tlast;
  logic        o_dp_rst_n;
  logic [2:0]  o_paicore_ctrl;
  logic        o_tx_en;
  logic        o_tx_done;
  logic        o_rx_done;
  logic        o_busy;
  logic        o_err_timeout;
  logic [2:0]  o_state;
  logic [31:0] o_tx_cnt;
  logic [31:0] o_rx_cnt;

  // Sequencer side
  modport slave (
    input  i_start, i_abort, i_send_len, i_frame_num_max, i_tx_beat, i_rx_tlast,
    output o_dp_rst_n, o_paicore_ctrl, o_tx_en, o_tx_done, o_rx_done, o_busy,
           o_err_timeout, o_state, o_tx_cnt, o_rx_cnt
  );

  // Regfile / datapath side
  modport master (
    output i_start, i_abort, i_send_len, i_frame_num_max, i_tx_beat, i_rx_tlast,
    input  o_dp_rst_n, o_paicore_ctrl, o_tx_en, o_tx_done, o_rx_done, o_busy,
           o_err_timeout, o_state, o_tx_cnt, o_rx_cnt
  );
endinterface

// File: rtl/paicore_run_sequencer.sv
// Sequences one PAICORE inference run: datapath reset pulse, core init phase,
// gated send of send_len beats, then collection of frame_num_max output frames.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   bus        : paicore_run_sequencer_if.slave (config/strobes in, control/status out)
// All outputs are flops loaded from the next-state values.
module paicore_run_sequencer #(
  parameter int unsigned RST_CYCLES     = 16,
  parameter int unsigned INIT_CYCLES    = 64,
  parameter int unsigned TIMEOUT_CYCLES = 32'd1048576
) (
  input  logic                          clk,
  input  logic                          rst_n,
  paicore_run_sequencer_if.slave        bus
);

  localparam int unsigned CW = 32;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_DP_RST  = 3'd1,
    S_INIT    = 3'd2,
    S_SEND    = 3'd3,
    S_WAIT_RX = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t        state, state_next;
  logic [CW-1:0] cyc, cyc_next;
  logic          abort_pend, abort_pend_next;
  logic [CW-1:0] send_len, send_len_next;
  logic [CW-1:0] frame_max, frame_max_next;
  logic [CW-1:0] tx_cnt, tx_cnt_next;
  logic [CW-1:0] rx_cnt, rx_cnt_next;
  logic          tx_done, tx_done_next;
  logic          rx_done, rx_done_next;
  logic          err, err_next;
  logic          tx_en, tx_en_next;
  logic          dp_rst_n, dp_rst_n_next;
  logic [2:0]    ctrl, ctrl_next;
  logic          busy, busy_next;

  logic abort_hit, start_ok, tx_acc, rx_acc;

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cyc        <= '0;
      abort_pend <= 1'b0;
      send_len   <= '0;
      frame_max  <= '0;
      tx_cnt     <= '0;
      rx_cnt     <= '0;
      tx_done    <= 1'b0;
      rx_done    <= 1'b0;
      err        <= 1'b0;
      tx_en      <= 1'b0;
      dp_rst_n   <= 1'b1;
      ctrl       <= 3'b000;
      busy       <= 1'b0;
    end else begin
      state      <= state_next;
      cyc        <= cyc_next;
      abort_pend <= abort_pend_next;
      send_len   <= send_len_next;
      frame_max  <= frame_max_next;
      tx_cnt     <= tx_cnt_next;
      rx_cnt     <= rx_cnt_next;
      tx_done    <= tx_done_next;
      rx_done    <= rx_done_next;
      err        <= err_next;
      tx_en      <= tx_en_next;
      dp_rst_n   <= dp_rst_n_next;
      ctrl       <= ctrl_next;
      busy       <= busy_next;
    end
  end

  // Next-state, counters and next output values
  always_comb begin
    state_next      = state;
    cyc_next        = cyc;
    abort_pend_next = abort_pend;
    send_len_next   = send_len;
    frame_max_next  = frame_max;
    tx_cnt_next     = tx_cnt;
    rx_cnt_next     = rx_cnt;
    tx_done_next    = tx_done;
    rx_done_next    = rx_done;
    err_next        = err;

    abort_hit = bus.i_abort && (state != S_IDLE);
    start_ok  = bus.i_start && !bus.i_abort && (state == S_IDLE || state == S_DONE);
    // Counters saturate at their targets and freeze on abort
    tx_acc    = bus.i_tx_beat && (state == S_SEND) && (tx_cnt != send_len) && !abort_hit;
    rx_acc    = bus.i_rx_tlast && (state == S_SEND || state == S_WAIT_RX) &&
                (rx_cnt != frame_max) && !abort_hit;

    if (tx_acc) tx_cnt_next = tx_cnt + CW'(1);
    if (rx_acc) rx_cnt_next = rx_cnt + CW'(1);

    if (abort_hit) begin
      // Reset the datapath, then fall back to IDLE without flagging done
      state_next      = S_DP_RST;
      cyc_next        = '0;
      abort_pend_next = 1'b1;
    end else begin
      unique case (state)
        S_IDLE, S_DONE: begin
          if (start_ok) begin
            state_next      = S_DP_RST;
            cyc_next        = '0;
            abort_pend_next = 1'b0;
            send_len_next   = bus.i_send_len;
            frame_max_next  = bus.i_frame_num_max;
            tx_cnt_next     = '0;
            rx_cnt_next     = '0;
            tx_done_next    = 1'b0;
            rx_done_next    = 1'b0;
            err_next        = 1'b0;
          end
        end
        S_DP_RST: begin
          if (cyc == CW'(RST_CYCLES - 1)) begin
            state_next      = abort_pend ? S_IDLE : S_INIT;
            cyc_next        = '0;
            abort_pend_next = 1'b0;
          end else begin
            cyc_next = cyc + CW'(1);
          end
        end
        S_INIT: begin
          if (cyc == CW'(INIT_CYCLES - 1)) begin
            state_next = S_SEND;
            cyc_next   = '0;
          end else begin
            cyc_next = cyc + CW'(1);
          end
        end
        S_SEND: begin
          // Covers send_len==0: leaves after a single cycle
          if (tx_cnt_next == send_len) begin
            state_next   = S_WAIT_RX;
            cyc_next     = '0;
            tx_done_next = 1'b1;
          end
        end
        S_WAIT_RX: begin
          if (rx_cnt == frame_max) begin
            state_next   = S_DONE;
            rx_done_next = 1'b1;
            tx_done_next = 1'b1;
          end else if (bus.i_rx_tlast) begin
            cyc_next = '0;
          end else if ((TIMEOUT_CYCLES != 0) && (cyc + CW'(1) == CW'(TIMEOUT_CYCLES))) begin
            state_next   = S_DONE;
            rx_done_next = 1'b1;
            tx_done_next = 1'b1;
            err_next     = 1'b1;
          end else begin
            cyc_next = cyc + CW'(1);
          end
        end
        default: state_next = S_IDLE;
      endcase
    end

    tx_en_next    = (state_next == S_SEND) && (tx_cnt_next != send_len_next);
    dp_rst_n_next = (state_next != S_DP_RST);
    busy_next     = (state_next != S_IDLE) && (state_next != S_DONE);
    unique case (state_next)
      S_INIT:              ctrl_next = 3'b001;
      S_SEND, S_WAIT_RX:   ctrl_next = 3'b010;
      S_DONE:              ctrl_next = 3'b100;
      default:             ctrl_next = 3'b000;
    endcase
  end

  assign bus.o_dp_rst_n     = dp_rst_n;
  assign bus.o_paicore_ctrl = ctrl;
  assign bus.o_tx_en        = tx_en;
  assign bus.o_tx_done      = tx_done;
  assign bus.o_rx_done      = rx_done;
  assign bus.o_busy         = busy;
  assign bus.o_err_timeout  = err;
  assign bus.o_state        = state;
  assign bus.o_tx_cnt       = tx_cnt;
  assign bus.o_rx_cnt       = rx_cnt;

endmodule
